bcp_sweep_ctrl: RTL and testbench

Sequential driver for clause-level Boolean constraint propagation. It holds a small clause buffer and accepts one decision literal at a time. For each decision it sweeps every stored clause, one per cycle, and writes the pruned clause back. Unit clauses produce implications, which go into an output FIFO toward the decision/trail logic. A clause that becomes empty raises a conflict. The block sits between the solver's decision unit and the per-clause propagation datapath.

---
 rtl/bcp_pkg.sv | 19 +
 rtl/bcp_imp_fifo.sv | 65 ++++++
 rtl/bcp_sweep_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_bcp_sweep_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcp_pkg.sv
// Shared types and constants for the clause-level BCP sweep controller.
// Literals are signed; zero marks an empty slot within a clause.
package bcp_pkg;

   localparam int LIT_INDEX_MAX = 1024;
   localparam int CLA_LENGTH    = 3;
   localparam int LW            = $clog2(LIT_INDEX_MAX) + 1;
   localparam int NW            = $clog2(CLA_LENGTH + 1);

   typedef logic signed [LW-1:0] lit_t;
   typedef lit_t [CLA_LENGTH-1:0] clause_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_CONFLICT
   } sweep_state_e;

endpackage

// File: rtl/bcp_imp_fifo.sv
// Implication FIFO with full/empty flags, flush, and a parallel compare of a
// candidate literal (and its negation) against every occupied entry.
module bcp_imp_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 11,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head,
   input  logic [W-1:0] cmp_lit,
   output logic         cmp_eq,
   output logic         cmp_neg
);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_q;
   logic [AW:0]  rd_q;
   logic [AW:0]  count;
   logic         do_push;
   logic         do_pop;

   assign count   = wr_q - rd_q;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (wr_q == rd_q);
   assign head    = empty ? '0 : mem[rd_q[AW-1:0]];
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_q[AW-1:0]] <= push_data;
   end

   always_comb begin
      cmp_eq  = 1'b0;
      cmp_neg = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((AW+1)'(k) < count) begin
            if (mem[rd_q[AW-1:0] + AW'(k)] == cmp_lit)  cmp_eq  = 1'b1;
            if (mem[rd_q[AW-1:0] + AW'(k)] == -cmp_lit) cmp_neg = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcp_sweep_ctrl.sv
// Sequential BCP driver: sweeps the clause buffer once per decision, prunes
// clauses, emits implications and flags conflicts. Optional: BCP_IMP_DEDUP_EN.
module bcp_sweep_ctrl
   import bcp_pkg::*;
#(
   parameter int NUM_CLAUSES    = 16,
   parameter int IMP_FIFO_DEPTH = 8,
   localparam int CW            = $clog2(NUM_CLAUSES)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load_valid,
   input  logic [CW-1:0]                load_idx,
   input  logic signed [CLA_LENGTH*LW-1:0] load_clause,
   input  logic                         dec_valid,
   output logic                         dec_ready,
   input  logic signed [LW-1:0]         dec_lit,
   output logic                         imp_valid,
   input  logic                         imp_ready,
   output logic signed [LW-1:0]         imp_lit,
   output logic                         conflict,
   output logic [CW-1:0]                conflict_idx,
   output logic                         sweep_done,
   output logic                         sat_all,
   output logic                         busy,
   input  logic                         clear
);

   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CLAUSES - 1);

   sweep_state_e     state_q, state_d;
   lit_t             d_q;
   logic [CW-1:0]    idx_q;
   logic [NUM_CLAUSES-1:0] valid_q, valid_d;
   clause_t          clauses [NUM_CLAUSES];

   clause_t          cur, pruned;
   lit_t             neg_d, rem;
   logic             hit;
   logic [NW-1:0]    n;

   logic             load_en, dec_take, pop;
   logic             idx_adv, wb, retire, push, go_conflict, finish;
   logic             fifo_full, fifo_empty, cmp_eq, cmp_neg;
   logic [LW-1:0]    fifo_head;

   assign load_en   = (state_q == S_IDLE) && load_valid;
   assign dec_ready = (state_q == S_IDLE) && !clear;
   assign dec_take  = dec_ready && dec_valid;
   assign pop       = imp_valid && imp_ready;
   assign busy      = (state_q != S_IDLE);
   assign conflict  = (state_q == S_CONFLICT);
   assign imp_valid = !fifo_empty;
   assign imp_lit   = fifo_head;

   // Prune the entry under the sweep pointer and count what survives.
   always_comb begin
      cur   = clauses[idx_q];
      neg_d = -d_q;
      hit   = 1'b0;
      n     = '0;
      rem   = '0;
      pruned = cur;
      for (int k = 0; k < CLA_LENGTH; k++) begin
         if (cur[k] == d_q) hit = 1'b1;
         pruned[k] = (cur[k] == neg_d) ? lit_t'(0) : cur[k];
         if (pruned[k] != lit_t'(0)) begin
            n   = n + 1'b1;
            rem = pruned[k];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_adv     = 1'b0;
      wb          = 1'b0;
      retire      = 1'b0;
      push        = 1'b0;
      go_conflict = 1'b0;
      finish      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dec_take) state_d = S_SWEEP;
         end
         S_SWEEP: begin
            if (!valid_q[idx_q]) begin
               idx_adv = 1'b1;
            end else if (hit) begin
               retire  = 1'b1;
               idx_adv = 1'b1;
            end else if (n == NW'(0)) begin
               wb          = 1'b1;
               go_conflict = 1'b1;
            end else if (n == NW'(1)) begin
`ifdef BCP_IMP_DEDUP_EN
               if (cmp_neg) begin
                  wb          = 1'b1;
                  go_conflict = 1'b1;
               end else if (cmp_eq) begin
                  wb      = 1'b1;
                  idx_adv = 1'b1;
               end else if (!fifo_full || pop) begin
                  wb      = 1'b1;
                  push    = 1'b1;
                  idx_adv = 1'b1;
               end
`else
               if (!fifo_full || pop) begin
                  wb      = 1'b1;
                  push    = 1'b1;
                  idx_adv = 1'b1;
               end
`endif
            end else begin
               wb      = 1'b1;
               idx_adv = 1'b1;
            end
            if (go_conflict) begin
               state_d = S_CONFLICT;
            end else if (idx_adv && (idx_q == LAST_IDX)) begin
               state_d = S_IDLE;
               finish  = 1'b1;
            end
         end
         S_CONFLICT: begin
            state_d = S_CONFLICT;
         end
         default: state_d = S_IDLE;
      endcase
      // An abort discards whatever the current evaluation would have done.
      if (clear) begin
         state_d     = S_IDLE;
         idx_adv     = 1'b0;
         wb          = 1'b0;
         retire      = 1'b0;
         push        = 1'b0;
         go_conflict = 1'b0;
         finish      = 1'b0;
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (load_en) valid_d[load_idx] = 1'b1;
      if (retire)  valid_d[idx_q]    = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         d_q          <= '0;
         idx_q        <= '0;
         valid_q      <= '0;
         conflict_idx <= '0;
         sweep_done   <= 1'b0;
         sat_all      <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         sweep_done <= finish;
         sat_all    <= finish && (valid_d == '0);
         if (dec_take) begin
            d_q   <= dec_lit;
            idx_q <= '0;
         end else if (idx_adv) begin
            idx_q <= idx_q + 1'b1;
         end
         if (go_conflict) conflict_idx <= idx_q;
      end
   end

   // Clause payload needs no reset: valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (load_en)  clauses[load_idx] <= clause_t'(load_clause);
      else if (wb)  clauses[idx_q]    <= pruned;
   end

   bcp_imp_fifo #(
      .DEPTH (IMP_FIFO_DEPTH),
      .W     (LW)
   ) u_imp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (clear),
      .push      (push),
      .push_data (rem),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head),
      .cmp_lit   (rem),
      .cmp_eq    (cmp_eq),
      .cmp_neg   (cmp_neg)
   );

`ifndef BCP_IMP_DEDUP_EN
   logic unused_cmp;
   assign unused_cmp = cmp_eq | cmp_neg;
`endif

endmodule

// File: tb/tb_bcp_sweep_ctrl.sv
// Directed testbench for bcp_sweep_ctrl with 4 clauses and a 2-deep FIFO.
// Honours BCP_IMP_DEDUP_EN when checking duplicate implications.
module tb_bcp_sweep_ctrl;
   import bcp_pkg::*;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic                          load_valid;
   logic [1:0]                    load_idx;
   logic signed [CLA_LENGTH*LW-1:0] load_clause;
   logic                          dec_valid;
   logic                          dec_ready;
   logic signed [LW-1:0]          dec_lit;
   logic                          imp_valid;
   logic                          imp_ready;
   logic signed [LW-1:0]          imp_lit;
   logic                          conflict;
   logic [1:0]                    conflict_idx;
   logic                          sweep_done;
   logic                          sat_all;
   logic                          busy;
   logic                          clear;

   int total = 0;
   int bad   = 0;

   bcp_sweep_ctrl #(
      .NUM_CLAUSES    (4),
      .IMP_FIFO_DEPTH (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_valid   (load_valid),
      .load_idx     (load_idx),
      .load_clause  (load_clause),
      .dec_valid    (dec_valid),
      .dec_ready    (dec_ready),
      .dec_lit      (dec_lit),
      .imp_valid    (imp_valid),
      .imp_ready    (imp_ready),
      .imp_lit      (imp_lit),
      .conflict     (conflict),
      .conflict_idx (conflict_idx),
      .sweep_done   (sweep_done),
      .sat_all      (sat_all),
      .busy         (busy),
      .clear        (clear)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      load_valid  = 1'b0;
      load_idx    = '0;
      load_clause = '0;
      dec_valid   = 1'b0;
      dec_lit     = '0;
      imp_ready   = 1'b0;
      clear       = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic load(input int idx, input int a, input int b, input int c);
      load_valid  = 1'b1;
      load_idx    = 2'(idx);
      load_clause = {lit_t'(c), lit_t'(b), lit_t'(a)};
      tick();
      load_valid  = 1'b0;
   endtask

   task automatic decide(input int lit);
      dec_valid = 1'b1;
      dec_lit   = lit_t'(lit);
      tick();
      dec_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if ({dec_ready, imp_valid, conflict, sweep_done, sat_all, busy} !== 6'b100000 ||
          imp_lit !== 0 || conflict_idx !== 2'd0) begin
         bad++;
         $display("[TB] FAIL reset_values got rdy=%b iv=%b lit=%0d cf=%b ci=%0d sd=%b sa=%b busy=%b",
                  dec_ready, imp_valid, imp_lit, conflict, conflict_idx, sweep_done, sat_all, busy);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_prune_imply();
      do_reset();
      load(0, 5, -7, 9);
      load(1, -5, 2, 0);
      decide(5);
      tick(); tick(); tick();
      total++;
      if (sweep_done !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL prune_early_done got sd=%b busy=%b want sd=0 busy=1", sweep_done, busy);
      end
      tick();
      total++;
      if (sweep_done !== 1'b1 || sat_all !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL prune_done got sd=%b sa=%b busy=%b want 1 0 0", sweep_done, sat_all, busy);
      end
      total++;
      if (imp_valid !== 1'b1 || imp_lit !== 2) begin
         bad++;
         $display("[TB] FAIL prune_imp got valid=%b lit=%0d want 1 2", imp_valid, imp_lit);
      end
      imp_ready = 1'b1;
      tick();
      imp_ready = 1'b0;
      total++;
      if (imp_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL prune_drain got valid=%b want 0", imp_valid);
      end
      // C0 retired and C1 reduced to {2}: deciding -2 must empty C1 only.
      decide(-2);
      tick(); tick();
      total++;
      if (conflict !== 1'b1 || conflict_idx !== 2'd1) begin
         bad++;
         $display("[TB] FAIL prune_writeback got cf=%b idx=%0d want 1 1", conflict, conflict_idx);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_conflict();
      bit seen_done = 1'b0;
      do_reset();
      load(0, 3, 0, 0);
      decide(-3);
      tick();
      total++;
      if (conflict !== 1'b1 || conflict_idx !== 2'd0 || dec_ready !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL conflict_raise got cf=%b idx=%0d rdy=%b busy=%b want 1 0 0 1",
                  conflict, conflict_idx, dec_ready, busy);
      end
      for (int k = 0; k < 6; k++) begin
         if (sweep_done) seen_done = 1'b1;
         tick();
      end
      total++;
      if (seen_done || conflict !== 1'b1) begin
         bad++;
         $display("[TB] FAIL conflict_hold got done_seen=%b cf=%b want 0 1", seen_done, conflict);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      #1;
      total++;
      if (conflict !== 1'b0 || dec_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL conflict_clear got cf=%b rdy=%b busy=%b want 0 1 0", conflict, dec_ready, busy);
      end
   endtask

   task automatic test_load_and_dec();
      do_reset();
      load_valid  = 1'b1;
      load_idx    = 2'd0;
      load_clause = {lit_t'(0), lit_t'(0), lit_t'(2)};
      dec_valid   = 1'b1;
      dec_lit     = lit_t'(-2);
      tick();
      load_valid = 1'b0;
      dec_valid  = 1'b0;
      tick();
      total++;
      if (conflict !== 1'b1 || conflict_idx !== 2'd0) begin
         bad++;
         $display("[TB] FAIL load_and_dec got cf=%b idx=%0d want 1 0", conflict, conflict_idx);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_fifo_stall();
      int got [$];
      bit seen_done = 1'b0;
      do_reset();
      for (int k = 0; k < 3; k++) load(k, -1, 10 + k, 0);
      decide(1);
      for (int k = 0; k < 6; k++) tick();
      total++;
      if (busy !== 1'b1 || sweep_done !== 1'b0 || imp_lit !== 10) begin
         bad++;
         $display("[TB] FAIL stall_hold got busy=%b sd=%b head=%0d want 1 0 10", busy, sweep_done, imp_lit);
      end
      imp_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (imp_valid) got.push_back(int'(imp_lit));
         tick();
         if (sweep_done) seen_done = 1'b1;
      end
      imp_ready = 1'b0;
      total++;
      if (got.size() != 3) begin
         bad++;
         $display("[TB] FAIL stall_count got %0d want 3", got.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if (got[k] != 10 + k) begin
               bad++;
               $display("[TB] FAIL stall_order[%0d] got %0d want %0d", k, got[k], 10 + k);
            end
         end
      end
      total++;
      if (!seen_done || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL stall_done got done_seen=%b busy=%b want 1 0", seen_done, busy);
      end
   endtask

   task automatic test_all_sat();
      do_reset();
      load(0, 4, 1, 2);
      load(1, -3, 4, 0);
      load(2, 0, 0, 4);
      load(3, 4, -4, 6);
      decide(4);
      tick(); tick(); tick(); tick();
      total++;
      if (sweep_done !== 1'b1 || sat_all !== 1'b1 || imp_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL allsat_done got sd=%b sa=%b iv=%b want 1 1 0", sweep_done, sat_all, imp_valid);
      end
      // With every valid bit cleared, -4 finds nothing to prune or conflict on.
      decide(-4);
      tick(); tick(); tick(); tick();
      total++;
      if (sweep_done !== 1'b1 || sat_all !== 1'b1 || conflict !== 1'b0) begin
         bad++;
         $display("[TB] FAIL allsat_retired got sd=%b sa=%b cf=%b want 1 1 0", sweep_done, sat_all, conflict);
      end
   endtask

   task automatic test_reset_mid_sweep();
      do_reset();
      load(0, -1, 6, 0);
      load(1, -1, 7, 0);
      decide(1);
      tick();
      rst_n = 1'b0;
      #1;
      total++;
      if ({dec_ready, imp_valid, conflict, sweep_done, sat_all, busy} !== 6'b100000 || imp_lit !== 0) begin
         bad++;
         $display("[TB] FAIL midreset_outputs got rdy=%b iv=%b lit=%0d cf=%b sd=%b sa=%b busy=%b",
                  dec_ready, imp_valid, imp_lit, conflict, sweep_done, sat_all, busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      decide(1);
      tick(); tick(); tick(); tick();
      total++;
      if (sweep_done !== 1'b1 || sat_all !== 1'b1 || imp_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_cleared got sd=%b sa=%b iv=%b want 1 1 0", sweep_done, sat_all, imp_valid);
      end
   endtask

   task automatic test_duplicates();
      int pops = 0;
      int want;
      bit wrong_lit = 1'b0;
`ifdef BCP_IMP_DEDUP_EN
      want = 1;
`else
      want = 2;
`endif
      do_reset();
      load(0, -1, 6, 0);
      load(1, -1, 6, 0);
      decide(1);
      tick(); tick(); tick(); tick();
      total++;
      if (sweep_done !== 1'b1 || conflict !== 1'b0) begin
         bad++;
         $display("[TB] FAIL dup_done got sd=%b cf=%b want 1 0", sweep_done, conflict);
      end
      imp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (imp_valid) begin
            pops++;
            if (imp_lit !== 6) wrong_lit = 1'b1;
         end
         tick();
      end
      imp_ready = 1'b0;
      total++;
      if (pops != want || wrong_lit) begin
         bad++;
         $display("[TB] FAIL dup_count got %0d pops (bad_lit=%b) want %0d", pops, wrong_lit, want);
      end
   endtask

   initial begin
      $display("[TB] starting bcp_sweep_ctrl bench");
      test_reset();
      test_prune_imply();
      test_conflict();
      test_load_and_dec();
      test_fifo_stall();
      test_all_sat();
      test_reset_mid_sweep();
      test_duplicates();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
